// File: rtl/vram_fetch_arbiter_if.sv
// Word-wide single-port VRAM bus between the fetch arbiter
// (master) and the memory (slave).
interface vram_fetch_arbiter_if #(
    parameter int AW = 19
);
    logic          mem_req;
    logic          mem_we;
    logic [AW-2:0] mem_addr;
    logic [1:0]    mem_be;
    logic [15:0]   mem_wdata;
    logic [15:0]   mem_rdata;
    logic          mem_ack;
    logic          mem_err;

    modport master (
        output mem_req, mem_we, mem_addr, mem_be,
        output mem_wdata, mem_err,
        input  mem_rdata, mem_ack
    );

    modport slave (
        input  mem_req, mem_we, mem_addr, mem_be,
        input  mem_wdata, mem_err,
        output mem_rdata, mem_ack
    );
endinterface

// File: rtl/vram_fetch_arbiter.sv
// Single-port VRAM arbiter: two-word video fetch (priority)
// and non-preemptible CPU byte accesses over one 16-bit port.
module vram_fetch_arbiter #(
    parameter int AW      = 19,
    parameter int TIMEOUT = 15
) (
    input  logic          clk_sys,
    input  logic          reset,
    input  logic          vid_req,
    input  logic [AW-1:0] vid_addr1,
    input  logic [AW-1:0] vid_addr2,
    output logic [15:0]   vid_dout1,
    output logic [15:0]   vid_dout2,
    output logic          vid_done,
    output logic          vid_overrun,
    input  logic          cpu_req,
    input  logic          cpu_we,
    input  logic [AW-1:0] cpu_addr,
    input  logic [7:0]    cpu_din,
    output logic [7:0]    cpu_dout,
    output logic          cpu_ack,
    vram_fetch_arbiter_if.master bus
);
    typedef enum logic [1:0] {
        IDLE, V1, V2, CPU
    } state_t;

    state_t        state, state_nx;
    logic          vpend;
    logic [AW-2:0] lat_a1, lat_a2, cur_a2;
    logic [15:0]   temp1;
    logic [3:0]    tmo_cnt;
    logic          acked, tmo, fin;
    logic          issue_v1, issue_v2, issue_cpu;
    logic [15:0]   rdata;
    logic          vid_addr_unused;

    assign vid_addr_unused = vid_addr1[0] ^ vid_addr2[0];

    // An abort behaves like an ack that returned all ones.
    assign acked = bus.mem_req & bus.mem_ack;
    assign tmo   = bus.mem_req & ~bus.mem_ack
                 & (tmo_cnt == 4'(TIMEOUT - 1));
    assign fin   = acked | tmo;
    assign rdata = acked ? bus.mem_rdata : 16'hFFFF;

    always_ff @(posedge clk_sys) begin
        if (reset) state <= IDLE;
        else       state <= state_nx;
    end

    always_comb begin
        state_nx  = state;
        issue_v1  = 1'b0;
        issue_v2  = 1'b0;
        issue_cpu = 1'b0;
        unique case (state)
            IDLE: begin
                if (vpend) begin
                    state_nx = V1;
                    issue_v1 = 1'b1;
                end else if (cpu_req && !vid_req) begin
                    state_nx  = CPU;
                    issue_cpu = 1'b1;
                end
            end
            V1: if (fin) state_nx = V2;
            V2: begin
                issue_v2 = ~bus.mem_req;
                if (fin) state_nx = IDLE;
            end
            CPU: if (fin) state_nx = IDLE;
            default: state_nx = IDLE;
        endcase
    end

    always_ff @(posedge clk_sys) begin
        if (reset) begin
            vpend         <= 1'b0;
            lat_a1        <= '0;
            lat_a2        <= '0;
            cur_a2        <= '0;
            temp1         <= '0;
            tmo_cnt       <= '0;
            vid_dout1     <= '0;
            vid_dout2     <= '0;
            vid_done      <= 1'b0;
            vid_overrun   <= 1'b0;
            cpu_dout      <= '0;
            cpu_ack       <= 1'b0;
            bus.mem_req   <= 1'b0;
            bus.mem_we    <= 1'b0;
            bus.mem_addr  <= '0;
            bus.mem_be    <= '0;
            bus.mem_wdata <= '0;
            bus.mem_err   <= 1'b0;
        end else begin
            vid_done    <= 1'b0;
            vid_overrun <= 1'b0;
            cpu_ack     <= 1'b0;
            bus.mem_err <= tmo;
            // A new strobe always wins over the clear on issue.
            if (vid_req) begin
                lat_a1      <= vid_addr1[AW-1:1];
                lat_a2      <= vid_addr2[AW-1:1];
                vpend       <= 1'b1;
                vid_overrun <= vpend | (state == V1)
                             | (state == V2);
            end else if (issue_v1) begin
                vpend <= 1'b0;
            end
            if (bus.mem_req && !fin)
                tmo_cnt <= tmo_cnt + 4'd1;
            if (issue_v1) begin
                bus.mem_req  <= 1'b1;
                bus.mem_we   <= 1'b0;
                bus.mem_addr <= lat_a1;
                bus.mem_be   <= 2'b11;
                cur_a2       <= lat_a2;
                tmo_cnt      <= '0;
            end
            if (issue_v2) begin
                bus.mem_req  <= 1'b1;
                bus.mem_we   <= 1'b0;
                bus.mem_addr <= cur_a2;
                bus.mem_be   <= 2'b11;
                tmo_cnt      <= '0;
            end
            if (issue_cpu) begin
                bus.mem_req   <= 1'b1;
                bus.mem_we    <= cpu_we;
                bus.mem_addr  <= cpu_addr[AW-1:1];
                bus.mem_be    <= !cpu_we    ? 2'b11
                               : cpu_addr[0] ? 2'b10 : 2'b01;
                bus.mem_wdata <= {cpu_din, cpu_din};
                tmo_cnt       <= '0;
            end
            if (fin) begin
                bus.mem_req <= 1'b0;
                bus.mem_we  <= 1'b0;
                unique case (state)
                    V1: temp1 <= rdata;
                    V2: begin
                        vid_dout1 <= temp1;
                        vid_dout2 <= rdata;
                        vid_done  <= 1'b1;
                    end
                    CPU: begin
                        cpu_ack <= 1'b1;
                        if (!bus.mem_we)
                            cpu_dout <= cpu_addr[0] ? rdata[15:8]
                                                    : rdata[7:0];
                    end
                    default: ;
                endcase
            end
        end
    end
endmodule

// File: tb/tb_vram_fetch_arbiter.sv
// Randomized bench for vram_fetch_arbiter against a behavioural
// memory/reference model.
module tb_vram_fetch_arbiter;
    localparam int AW = 19;

    typedef struct packed {
        logic [17:0] addr;
        logic        we;
        logic [1:0]  be;
        logic [15:0] wdata;
    } acc_t;

    logic clk_sys = 1'b0;
    always #5 clk_sys = ~clk_sys;

    logic          reset;
    logic          vid_req;
    logic [AW-1:0] vid_addr1, vid_addr2;
    logic [15:0]   vid_dout1, vid_dout2;
    logic          vid_done, vid_overrun;
    logic          cpu_req, cpu_we;
    logic [AW-1:0] cpu_addr;
    logic [7:0]    cpu_din, cpu_dout;
    logic          cpu_ack;
    logic          mack = 1'b0;
    logic [15:0]   mrd = 16'h0;

    vram_fetch_arbiter_if #(.AW(AW)) bus();
    assign bus.mem_ack   = mack;
    assign bus.mem_rdata = mrd;

    vram_fetch_arbiter #(.AW(AW), .TIMEOUT(15)) dut (
        .clk_sys(clk_sys), .reset(reset),
        .vid_req(vid_req), .vid_addr1(vid_addr1),
        .vid_addr2(vid_addr2), .vid_dout1(vid_dout1),
        .vid_dout2(vid_dout2), .vid_done(vid_done),
        .vid_overrun(vid_overrun), .cpu_req(cpu_req),
        .cpu_we(cpu_we), .cpu_addr(cpu_addr),
        .cpu_din(cpu_din), .cpu_dout(cpu_dout),
        .cpu_ack(cpu_ack), .bus(bus)
    );

    int n_tests = 0;
    int n_fail  = 0;
    int cyc = 0, lat = 1, dead_at = -1, n_acc = 0;
    int rcnt = 0, hi = 0, last_hi = 0, n_ovr = 0, n_err = 0;
    bit req_prev = 1'b0, spur = 1'b0;
    acc_t        acc_q[$];
    logic [31:0] vdone_q[$];
    int          vdone_cyc[$];
    logic [7:0]  cack_q[$];
    int          cack_cyc[$];
    logic [15:0] ram[int];
    logic [15:0] ref_mem[int];

    task automatic check(input string tag, input logic [31:0] got,
                         input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    function automatic logic [15:0] fill(input logic [17:0] a);
        return 16'(a * 18'd40503) ^ 16'h1234;
    endfunction

    function automatic logic [15:0] rd_ram(input logic [17:0] a);
        return ram.exists(int'(a)) ? ram[int'(a)] : fill(a);
    endfunction

    function automatic logic [15:0] rd_ref(input logic [17:0] a);
        return ref_mem.exists(int'(a)) ? ref_mem[int'(a)] : fill(a);
    endfunction

    // Reference view of a CPU byte write.
    task automatic wr_ref(input logic [18:0] a, input logic [7:0] d);
        logic [15:0] w;
        w = rd_ref(a[18:1]);
        if (a[0]) w[15:8] = d;
        else      w[7:0]  = d;
        ref_mem[int'(a[18:1])] = w;
    endtask

    // Memory responder and output monitor, sampled 1 unit after the edge.
    always @(posedge clk_sys) begin
        logic [15:0] w;
        #1;
        cyc++;
        if (vid_done) begin
            vdone_q.push_back({vid_dout1, vid_dout2});
            vdone_cyc.push_back(cyc);
        end
        if (cpu_ack) begin
            cack_q.push_back(cpu_dout);
            cack_cyc.push_back(cyc);
        end
        if (vid_overrun) n_ovr++;
        if (bus.mem_err) n_err++;
        if (mack) begin
            mack = 1'b0;
        end else if (spur) begin
            mack = 1'b1;
            spur = 1'b0;
        end else if (bus.mem_req) begin
            if (!req_prev) begin
                rcnt = lat;
                hi = 0;
                n_acc++;
                acc_q.push_back('{bus.mem_addr, bus.mem_we,
                                  bus.mem_be, bus.mem_wdata});
            end
            hi++;
            if (n_acc != dead_at) begin
                if (rcnt == 0) begin
                    mack = 1'b1;
                    w = rd_ram(bus.mem_addr);
                    if (bus.mem_we) begin
                        if (bus.mem_be[0]) w[7:0]  = bus.mem_wdata[7:0];
                        if (bus.mem_be[1]) w[15:8] = bus.mem_wdata[15:8];
                        ram[int'(bus.mem_addr)] = w;
                    end
                    mrd = w;
                end else begin
                    rcnt--;
                end
            end
        end
        if (req_prev && !bus.mem_req) last_hi = hi;
        req_prev = bus.mem_req;
    end

    task automatic tick();
        @(posedge clk_sys);
        #2;
    endtask

    task automatic clr();
        acc_q.delete();
        vdone_q.delete();
        vdone_cyc.delete();
        cack_q.delete();
        cack_cyc.delete();
        n_ovr = 0;
        n_err = 0;
    endtask

    task automatic wait_ev(input int nv, input int nc);
        int w;
        w = 0;
        while (w < 400 && (vdone_q.size() < nv || cack_q.size() < nc)) begin
            tick();
            w++;
            if (cack_q.size() >= nc) cpu_req = 1'b0;
        end
        cpu_req = 1'b0;
        check("wait_bound", 32'(w < 400), 1);
        tick();
        tick();
    endtask

    task automatic chk_acc(input int i, input logic [17:0] a,
                           input logic we, input logic [1:0] be,
                           input bit cw, input logic [15:0] wd);
        check("acc_addr", acc_q[i].addr, a);
        check("acc_we", acc_q[i].we, we);
        check("acc_be", acc_q[i].be, be);
        if (cw) check("acc_wdata", acc_q[i].wdata, wd);
    endtask

    task automatic run_txn(input bit dv, input logic [18:0] a1,
                           input logic [18:0] a2, input bit dc,
                           input bit we, input logic [18:0] ca,
                           input logic [7:0] cd);
        int t0, nexp;
        logic [15:0] e1, e2, cw;
        logic [1:0]  ebe;
        clr();
        e1  = rd_ref(a1[18:1]);
        e2  = rd_ref(a2[18:1]);
        cw  = rd_ref(ca[18:1]);
        ebe = !we ? 2'b11 : (ca[0] ? 2'b10 : 2'b01);
        vid_req = dv; vid_addr1 = a1; vid_addr2 = a2;
        cpu_req = dc; cpu_we = we; cpu_addr = ca; cpu_din = cd;
        tick();
        t0 = cyc;
        vid_req = 1'b0;
        wait_ev(int'(dv), int'(dc));
        nexp = 2 * int'(dv) + int'(dc);
        check("acc_cnt", acc_q.size(), nexp);
        check("ovr_none", n_ovr, 0);
        if (dv) begin
            check("vdone_cnt", vdone_q.size(), 1);
            if (vdone_q.size() == 1) begin
                check("vid_dout1", vdone_q[0][31:16], e1);
                check("vid_dout2", vdone_q[0][15:0], e2);
                check("vid_lat", vdone_cyc[0] - t0, 2 * lat + 4);
            end
            if (acc_q.size() == nexp) begin
                chk_acc(0, a1[18:1], 1'b0, 2'b11, 1'b0, 16'h0);
                chk_acc(1, a2[18:1], 1'b0, 2'b11, 1'b0, 16'h0);
            end
        end
        if (dc) begin
            check("cack_cnt", cack_q.size(), 1);
            if (cack_q.size() == 1) begin
                if (!we)
                    check("cpu_dout", cack_q[0],
                          ca[0] ? cw[15:8] : cw[7:0]);
                check("cpu_lat", cack_cyc[0] - t0,
                      dv ? 3 * lat + 6 : lat + 1);
            end
            if (acc_q.size() == nexp)
                chk_acc(2 * int'(dv), ca[18:1], we, ebe, we, {cd, cd});
            if (we) wr_ref(ca, cd);
        end
    endtask

    initial begin
        int na;
        reset = 1'b1;
        vid_req = 1'b0; vid_addr1 = '0; vid_addr2 = '0;
        cpu_req = 1'b0; cpu_we = 1'b0; cpu_addr = '0; cpu_din = '0;
        tick(); tick(); tick();
        check("rst_dout1", vid_dout1, 0);
        check("rst_dout2", vid_dout2, 0);
        check("rst_cpu_dout", cpu_dout, 0);
        check("rst_mem_req", bus.mem_req, 0);
        check("rst_pulses", {vid_done, vid_overrun, cpu_ack, bus.mem_err}, 0);
        reset = 1'b0;
        tick();

        lat = 1;
        run_txn(1, 19'h00010, 19'h06010, 0, 0, '0, '0);
        ram[18'h80] = 16'hA55A;
        ref_mem[18'h80] = 16'hA55A;
        run_txn(0, '0, '0, 1, 0, 19'h00101, '0);
        run_txn(0, '0, '0, 1, 1, 19'h00100, 8'h3C);
        run_txn(0, '0, '0, 1, 0, 19'h00100, '0);
        run_txn(1, 19'h00101, 19'h00200, 1, 0, 19'h00101, '0);

        // vid_req while a CPU access is in flight
        clr();
        lat = 3;
        cpu_req = 1'b1; cpu_we = 1'b0; cpu_addr = 19'h00040;
        vid_addr1 = 19'h00022; vid_addr2 = 19'h00044;
        tick(); tick();
        vid_req = 1'b1;
        tick();
        vid_req = 1'b0;
        wait_ev(1, 1);
        check("mid_order", 32'(cack_cyc.size() == 1 && vdone_cyc.size() == 1
                           && cack_cyc[0] < vdone_cyc[0]), 1);
        check("mid_ovr", n_ovr, 0);
        check("mid_acc", acc_q.size(), 3);
        if (acc_q.size() == 3) check("mid_a0", acc_q[0].addr, 18'h20);

        // second vid_req during V1
        clr();
        lat = 2;
        vid_req = 1'b1; vid_addr1 = 19'h00300; vid_addr2 = 19'h00302;
        tick();
        vid_req = 1'b0;
        tick();
        vid_req = 1'b1; vid_addr1 = 19'h00500; vid_addr2 = 19'h00504;
        tick();
        vid_req = 1'b0;
        wait_ev(2, 0);
        check("ovr_cnt", n_ovr, 1);
        check("ovr_done", vdone_q.size(), 2);
        if (vdone_q.size() == 2) begin
            check("ovr_a", vdone_q[0], {rd_ref(18'h180), rd_ref(18'h181)});
            check("ovr_b", vdone_q[1], {rd_ref(18'h280), rd_ref(18'h282)});
        end
        check("ovr_acc", acc_q.size(), 4);
        if (acc_q.size() == 4) check("ovr_a3", acc_q[3].addr, 18'h282);

        // no ack on the second word
        clr();
        lat = 1;
        dead_at = n_acc + 2;
        vid_req = 1'b1; vid_addr1 = 19'h00010; vid_addr2 = 19'h00012;
        tick();
        vid_req = 1'b0;
        wait_ev(1, 0);
        dead_at = -1;
        check("tmo_err", n_err, 1);
        check("tmo_hi", last_hi, 15);
        if (vdone_q.size() == 1)
            check("tmo_data", vdone_q[0], {rd_ref(18'h8), 16'hFFFF});
        else
            check("tmo_done", vdone_q.size(), 1);

        // no ack on a CPU read
        clr();
        dead_at = n_acc + 1;
        cpu_req = 1'b1; cpu_we = 1'b0; cpu_addr = 19'h00101;
        wait_ev(0, 1);
        dead_at = -1;
        check("tmo_cerr", n_err, 1);
        check("tmo_cack", cack_q.size(), 1);
        if (cack_q.size() == 1) check("tmo_cdout", cack_q[0], 8'hFF);

        // stray ack while idle
        clr();
        spur = 1'b1;
        repeat (4) tick();
        check("spur_acc", acc_q.size(), 0);
        check("spur_ev", vdone_q.size() + cack_q.size() + n_err, 0);

        // random traffic
        for (int i = 0; i < 40; i++) begin
            int k;
            lat = $urandom_range(1, 4);
            k = $urandom_range(0, 3);
            run_txn(k == 0 || k == 3, 19'($urandom_range(0, 511)),
                    19'($urandom_range(0, 511)), k != 0,
                    k == 2, 19'($urandom_range(0, 63)),
                    8'($urandom_range(0, 255)));
        end

        // reset in the middle of V1
        clr();
        lat = 8;
        vid_req = 1'b1; vid_addr1 = 19'h00600; vid_addr2 = 19'h00602;
        tick();
        vid_req = 1'b0;
        tick();
        check("pre_rst_req", bus.mem_req, 1);
        reset = 1'b1;
        tick();
        check("mid_rst_req", bus.mem_req, 0);
        check("mid_rst_d1", vid_dout1, 0);
        check("mid_rst_d2", vid_dout2, 0);
        check("mid_rst_cd", cpu_dout, 0);
        reset = 1'b0;
        na = acc_q.size();
        repeat (12) tick();
        check("post_rst_acc", acc_q.size(), na);
        check("post_rst_done", vdone_q.size(), 0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
